// File: rtl/ysyx_23060061_mem_pkg.sv
// Shared encodings and default widths for the IFU/LSU memory arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ysyx_23060061_mem_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    // Owner of the single outstanding transaction
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Default bus widths
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/ysyx_23060061_Reg.sv
// Generic load-enabled register with synchronous active-high reset.
// Latency: 1 cycle from din/wen to dout.
// Backpressure: none; holds value whenever wen is low.
module ysyx_23060061_Reg #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    // Capture din on wen; reset dominates
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one memory port arbiter, LSU fixed priority.
// Latency: accept at T, mem request from T+1, response passes through combinationally; 3 cycles min per txn.
// Backpressure: one txn outstanding; req_ready only in IDLE; mem_req_ready holds REQ, owner rsp_ready stalls mem_rsp_ready.
module ysyx_23060061_mem_arbiter
    import ysyx_23060061_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic                wen;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] wmask;
    } mem_req_t;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       owner_q;
    logic       in_idle;
    logic       in_req;
    logic       in_rsp;
    logic       req_accept;
    logic       owner_rsp_ready;
    mem_req_t   req_nxt;
    mem_req_t   req_q;

    // State decode; outputs are forced quiet while reset is asserted so
    // nothing handshakes during the reset cycle itself
    assign in_idle = ~rst & (state_q == ST_IDLE);
    assign in_req  = ~rst & (state_q == ST_REQ);
    assign in_rsp  = ~rst & (state_q == ST_RSP);

    // Grant: LSU wins ties; IFU must hold its valid until a later IDLE
    always_comb begin
        lsu_req_ready = in_idle & lsu_req_valid;
        ifu_req_ready = in_idle & ifu_req_valid & ~lsu_req_valid;
        req_accept    = lsu_req_ready | ifu_req_ready;
    end

    // Select the fields to latch; IFU fetches are plain reads
    always_comb begin
        req_nxt = '0;
        if (lsu_req_valid) begin
            req_nxt.addr  = lsu_addr;
            req_nxt.wen   = lsu_wen;
            req_nxt.wdata = lsu_wdata;
            req_nxt.wmask = lsu_wmask;
        end else begin
            req_nxt.addr  = ifu_addr;
        end
    end

    // Latched request, held stable for the whole transaction
    ysyx_23060061_Reg #(
        .WIDTH     ($bits(mem_req_t)),
        .RESET_VAL ('0)
    ) u_req_reg (
        .clk  (clk),
        .rst  (rst),
        .din  (req_nxt),
        .dout (req_q),
        .wen  (req_accept)
    );

    // Record which master owns the outstanding transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_IFU;
        end else if (req_accept) begin
            owner_q <= lsu_req_ready ? OWN_LSU : OWN_IFU;
        end
    end

    // Next-state: IDLE -> REQ on accept, REQ -> RSP on mem accept, RSP -> IDLE on response handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_accept)                    state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready)                 state_d = ST_RSP;
            ST_RSP:  if (mem_rsp_valid && mem_rsp_ready) state_d = ST_IDLE;
            default:                                    state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Downstream request side
    assign mem_req_valid = in_req;
    assign mem_addr      = req_q.addr;
    assign mem_wen       = req_q.wen;
    assign mem_wdata     = req_q.wdata;
    assign mem_wmask     = req_q.wmask;

    // Response steering: only the owner sees valid; the owner's ready throttles memory
    always_comb begin
        owner_rsp_ready = (owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
        mem_rsp_ready   = in_rsp & owner_rsp_ready;
        ifu_rsp_valid   = in_rsp & (owner_q == OWN_IFU) & mem_rsp_valid;
        lsu_rsp_valid   = in_rsp & (owner_q == OWN_LSU) & mem_rsp_valid;
    end

    // Read data is not registered
    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter with a scoreboarded memory model.
// Latency: drives at posedge+1, checks at posedge+3, scoreboard samples at negedge.
// Backpressure: memory request delay and master rsp_ready are bench-controlled.
module tb_ysyx_23060061_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    ysyx_23060061_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rdata     (ifu_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        logic        own;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_e;

    typedef struct {
        logic        own;
        logic        wen;
        logic [31:0] data;
    } rsp_e;

    req_e q_req[$];
    rsp_e q_rsp[$];

    int n_chk = 0;
    int n_fail = 0;
    int delivered = 0;
    int mem_req_cnt = 0;
    int req_delay = 0;
    int wait_cnt = 0;
    logic req_hs = 1'b0;
    logic rsp_hs = 1'b0;
    logic rst_seen = 1'b0;
    logic [31:0] hs_addr = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_5A5A);
    endfunction

    task automatic deliver(input logic own, input logic [31:0] data);
        rsp_e r;
        delivered++;
        check_eq("rsp_expected", q_rsp.size() != 0, 1);
        if (q_rsp.size() != 0) begin
            r = q_rsp.pop_front();
            check_eq("rsp_owner", own, r.own);
            if (!r.wen) check_eq("rsp_data", data, r.data);
        end
    endtask

    // Scoreboard monitor: sample settled handshakes at negedge
    initial begin
        req_e e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_req.delete();
                q_rsp.delete();
                rst_seen = 1'b1;
            end else begin
                if (ifu_req_valid && ifu_req_ready)
                    q_req.push_back('{1'b0, ifu_addr, 1'b0, 32'h0, 4'h0});
                if (lsu_req_valid && lsu_req_ready)
                    q_req.push_back('{1'b1, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask});
                if (mem_req_valid && mem_req_ready) begin
                    mem_req_cnt++;
                    req_hs  = 1'b1;
                    hs_addr = mem_addr;
                    check_eq("mem_req_expected", q_req.size() != 0, 1);
                    if (q_req.size() != 0) begin
                        e = q_req.pop_front();
                        check_eq("mem_addr", mem_addr, e.addr);
                        check_eq("mem_wen", mem_wen, e.wen);
                        check_eq("mem_wdata", mem_wdata, e.wdata);
                        check_eq("mem_wmask", mem_wmask, e.wmask);
                        q_rsp.push_back('{e.own, e.wen, mem_model(e.addr)});
                    end
                end
                if (mem_rsp_valid && mem_rsp_ready) rsp_hs = 1'b1;
                if (ifu_rsp_valid && ifu_rsp_ready) deliver(1'b0, ifu_rdata);
                if (lsu_rsp_valid && lsu_rsp_ready) deliver(1'b1, lsu_rdata);
            end
        end
    end

    // Memory slave: accepts after req_delay cycles, answers the cycle after accept
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_seen) begin
                mem_rsp_valid = 1'b0;
                wait_cnt = 0;
                rst_seen = 1'b0;
                req_hs   = 1'b0;
                rsp_hs   = 1'b0;
            end else begin
                if (rsp_hs) begin
                    mem_rsp_valid = 1'b0;
                    rsp_hs = 1'b0;
                end
                if (req_hs) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata = mem_model(hs_addr);
                    req_hs = 1'b0;
                    wait_cnt = 0;
                end
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                mem_req_ready = (wait_cnt >= req_delay);
                wait_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input int max_cyc);
        int start = delivered;
        int n = 0;
        while (delivered == start && n < max_cyc) begin
            step();
            n++;
        end
        check_eq(tag, delivered != start, 1);
        step();
    endtask

    task automatic issue_ifu(input string tag, input logic [31:0] a);
        step();
        ifu_req_valid = 1'b1;
        ifu_addr = a;
        #2;
        check_eq(tag, ifu_req_ready, 1);
        step();
        ifu_req_valid = 1'b0;
        wait_rsp({tag, "_done"}, 20);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses, ifu_seen, ok_cnt, d0, m0;
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = '0; ifu_rsp_ready = 1;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_rsp_ready = 1;
        step(); step();
        rst = 1'b0;
        #2;
        check_eq("rst_mem_req_valid", mem_req_valid, 0);
        check_eq("rst_mem_rsp_ready", mem_rsp_ready, 0);
        check_eq("rst_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_fields", {mem_wen, mem_wmask, mem_wdata}, 0);

        // IFU-only read with exact timing
        step(); ifu_req_valid = 1; ifu_addr = 32'h8000_0000; #2;
        check_eq("t1_ifu_ready", ifu_req_ready, 1);
        check_eq("t1_lsu_ready", lsu_req_ready, 0);
        step(); ifu_req_valid = 0; #2;
        check_eq("t1_mem_req_valid", mem_req_valid, 1);
        check_eq("t1_mem_addr", mem_addr, 32'h8000_0000);
        check_eq("t1_mem_wen", mem_wen, 0);
        check_eq("t1_busy_ready", ifu_req_ready, 0);
        step(); #2;
        check_eq("t1_ifu_rsp_valid", ifu_rsp_valid, 1);
        check_eq("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        check_eq("t1_lsu_rsp_valid", lsu_rsp_valid, 0);
        step(); #2;
        check_eq("t1_after_rsp_valid", ifu_rsp_valid, 0);
        check_eq("t1_after_mem_req", mem_req_valid, 0);

        // LSU write
        step();
        lsu_req_valid = 1; lsu_addr = 32'h8000_1004; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; #2;
        check_eq("t2_lsu_ready", lsu_req_ready, 1);
        step(); lsu_req_valid = 0; #2;
        check_eq("t2_mem_addr", mem_addr, 32'h8000_1004);
        check_eq("t2_mem_wen", mem_wen, 1);
        check_eq("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_eq("t2_mem_wmask", mem_wmask, 4'b0011);
        pulses = 0; ifu_seen = 0;
        repeat (5) begin
            step(); #2;
            if (lsu_rsp_valid) pulses++;
            if (ifu_rsp_valid) ifu_seen++;
        end
        check_eq("t2_lsu_pulses", pulses, 1);
        check_eq("t2_ifu_pulses", ifu_seen, 0);

        // Both valid together: LSU first, IFU on the next IDLE
        step();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; #2;
        check_eq("t3_lsu_ready", lsu_req_ready, 1);
        check_eq("t3_ifu_ready", ifu_req_ready, 0);
        step(); lsu_req_valid = 0; #2;
        check_eq("t3_mem_addr_lsu", mem_addr, 32'h8000_2000);
        check_eq("t3_ifu_ready_busy", ifu_req_ready, 0);
        step(); #2;
        check_eq("t3_lsu_rsp", lsu_rsp_valid, 1);
        check_eq("t3_ifu_rsp", ifu_rsp_valid, 0);
        step(); #2;
        check_eq("t3_ifu_grant", ifu_req_ready, 1);
        step(); ifu_req_valid = 0; #2;
        check_eq("t3_mem_addr_ifu", mem_addr, 32'h8000_0010);
        step(); #2;
        check_eq("t3_ifu_rsp2", ifu_rsp_valid, 1);
        step();

        // Memory request back-pressure for 5 cycles
        req_delay = 5;
        m0 = mem_req_cnt;
        step(); ifu_req_valid = 1; ifu_addr = 32'h8000_0020; #2;
        check_eq("t4_ifu_ready", ifu_req_ready, 1);
        step(); ifu_req_valid = 0;
        ok_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            #2;
            if (mem_req_valid && mem_addr == 32'h8000_0020 && !mem_wen) ok_cnt++;
        end
        check_eq("t4_stable_cycles", ok_cnt, 5);
        step(); #2;
        check_eq("t4_valid_cycle6", mem_req_valid, 1);
        step(); #2;
        check_eq("t4_req_dropped", mem_req_valid, 0);
        req_delay = 0;
        wait_rsp("t4_done", 20);
        check_eq("t4_single_req", mem_req_cnt - m0, 1);

        // Owner response back-pressure for 3 cycles
        d0 = delivered;
        step();
        lsu_rsp_ready = 0;
        lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 0; #2;
        check_eq("t5_lsu_ready", lsu_req_ready, 1);
        step(); lsu_req_valid = 0;
        ok_cnt = 0;
        repeat (3) begin
            step(); #2;
            if (!mem_rsp_ready && lsu_rsp_valid) ok_cnt++;
        end
        check_eq("t5_stall_cycles", ok_cnt, 3);
        step(); lsu_rsp_ready = 1; #2;
        check_eq("t5_mem_rsp_ready", mem_rsp_ready, 1);
        check_eq("t5_lsu_rdata", lsu_rdata, 32'h8000_3000 ^ 32'h5A5A_5A5A);
        step(); #2;
        check_eq("t5_rsp_dropped", lsu_rsp_valid, 0);
        check_eq("t5_single_delivery", delivered - d0, 1);

        // Reset while in RSP discards the transaction
        step(); ifu_rsp_ready = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0030; #2;
        check_eq("t6_ifu_ready", ifu_req_ready, 1);
        step(); ifu_req_valid = 0;
        step(); #2;
        check_eq("t6_in_rsp", ifu_rsp_valid, 1);
        d0 = delivered;
        step(); rst = 1;
        step(); rst = 0; ifu_rsp_ready = 1; #2;
        check_eq("t6_mem_req_valid", mem_req_valid, 0);
        check_eq("t6_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        check_eq("t6_mem_rsp_ready", mem_rsp_ready, 0);
        check_eq("t6_mem_addr_clr", mem_addr, 0);
        repeat (3) step();
        check_eq("t6_no_delivery", delivered - d0, 0);
        issue_ifu("t6_fresh", 32'h8000_0040);

        check_eq("end_req_queue", q_req.size(), 0);
        check_eq("end_rsp_queue", q_rsp.size(), 0);
        check_eq("end_delivered", delivered, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060061_mem_arbiter.md
# ysyx_23060061_mem_arbiter

Two-master, one-slave memory arbiter between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) of the multi-cycle core, driving the single shared physical-memory port. It accepts at most one transaction at a time, latches it, issues it downstream, and routes the response back to the owner. Both sides use valid/ready handshakes. LSU has fixed priority.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; write mask is DATA_W/8 bits

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_addr  in  ADDR_W  fetch address
- ifu_rsp_valid / ifu_rsp_ready  out / in  1  IFU response handshake
- ifu_rdata  out  DATA_W  fetched instruction
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_addr  in  ADDR_W  access address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  byte strobes
- lsu_rsp_valid / lsu_rsp_ready  out / in  1  LSU response handshake; also issued for writes
- lsu_rdata  out  DATA_W  load data (don't-care for writes)
- mem_req_valid / mem_req_ready  out / in  1  downstream request handshake
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  as LSU  latched request fields
- mem_rsp_valid / mem_rsp_ready  in / out  1  downstream response handshake
- mem_rdata  in  DATA_W  response data

## Operation
- States: IDLE, REQ, RSP. Owner register: IFU or LSU.
- IDLE:
  - If lsu_req_valid: lsu_req_ready=1; latch LSU fields; owner=LSU; go to REQ.
  - Else if ifu_req_valid: ifu_req_ready=1; latch addr with wen=0, wdata=0, wmask=0; owner=IFU; go to REQ.
  - Both ready signals are combinational from the valids, asserted in IDLE only.
- REQ: mem_req_valid=1 with the latched fields, held stable; on mem_req_ready go to RSP.
- RSP:
  - mem_rsp_ready mirrors the owner's rsp_ready.
  - Owner's rsp_valid mirrors mem_rsp_valid; its rdata = mem_rdata.
  - The non-owner's rsp_valid is 0.
  - On the mem_rsp_valid && mem_rsp_ready handshake, go to IDLE.
- Only one transaction is outstanding. Both req_ready outputs are 0 outside IDLE.
- Both requests valid in the same IDLE cycle: LSU wins. IFU ready stays 0; IFU must hold its request, which is granted on the next IDLE if LSU is not requesting.
- Master deasserting valid without a handshake: no effect; nothing is latched.
- Response data is not registered; it passes through combinationally.

## Timing
- Reset (any state): state=IDLE, owner=IFU, latched fields=0, mem_req_valid=0, mem_rsp_ready=0, all rsp_valid=0.
- Reset mid-transaction discards the transaction silently. No response is produced; masters re-issue.
- Cycle T: request accepted in IDLE.
- T+1: mem_req_valid=1 at the earliest.
- T+2: response forwarded at the earliest, with mem ready at T+1 and response at T+2.
- T+3: earliest next accept. Minimum 3 cycles per transaction, with one IDLE bubble.
- Back-pressure:
  - mem_req_ready low holds REQ indefinitely with fields stable.
  - Owner rsp_ready low holds RSP and stalls mem via mem_rsp_ready.
- A response arriving in REQ is not possible by protocol. The arbiter ignores mem_rsp_valid outside RSP (mem_rsp_ready=0).

## Structure
- Shared header/package ysyx_23060061_mem_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_REQ=2'd1, ST_RSP=2'd2
  - owner encodings OWN_IFU=1'b0, OWN_LSU=1'b1
  - default ADDR_W/DATA_W
- The request-holding register (addr, wen, wdata, wmask) uses the existing ysyx_23060061_Reg. No other sub-module; the FSM and steering logic are inline.

## Test plan
- IFU-only read, addr 0x80000000; mem ready immediately; rdata 0x00000413 at T+2 -> ifu_rsp_valid=1 with ifu_rdata=0x00000413 at T+2; IDLE at T+3; lsu_rsp_valid stays 0.
- LSU write, addr 0x80001004, wdata 0xDEADBEEF, wmask 4'b0011 -> mem fields match exactly; mem_wen=1; lsu_rsp_valid pulses once.
- Both valid in the same cycle (IFU 0x80000010, LSU read 0x80002000) -> LSU granted first, mem_addr=0x80002000. IFU granted on the first IDLE after LSU completes, mem_addr=0x80000010.
- mem_req_ready low for 5 cycles -> mem_req_valid and fields stable all 5 cycles; handshake on cycle 6; no second request issued.
- Owner rsp_ready low for 3 cycles while mem_rsp_valid=1 -> mem_rsp_ready=0 for 3 cycles; single delivery on cycle 4.
- rst pulsed for one cycle while in RSP -> next cycle IDLE with all valid outputs 0; no response delivered; a fresh IFU request is accepted afterwards.
